// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
// Shares the single instruction-memory port between the frontend fetch path
// (reads) and the boot/program loader (write bursts). Loader bursts lock the
// port; after LOAD_BURST_MAX consecutive beats with fetch waiting, one cycle
// is yielded to fetch. Fetch read data returns with a fixed 1-cycle latency.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_fe_req/i_fe_addr            fetch read request and PC
//   o_fe_gnt/o_fe_stall           fetch owns port / fetch is waiting
//   o_fe_rvalid/o_fe_rdata        read data, one cycle after o_fe_gnt
//   i_ld_req/i_ld_addr/i_ld_wdata/i_ld_last   loader write beat
//   o_ld_gnt                      loader beat accepted this cycle
//   o_mem_rq/o_mem_rnw/o_mem_addr/o_mem_wdata/i_mem_rdata   icache port
//   o_busy_load                   loader burst in progress
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = AWIDTH,
    parameter int LOAD_BURST_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fe_req,
    input  logic [AWIDTH-1:0] i_fe_addr,
    output logic              o_fe_gnt,
    output logic              o_fe_stall,
    output logic              o_fe_rvalid,
    output logic [DWIDTH-1:0] o_fe_rdata,
    input  logic              i_ld_req,
    input  logic [AWIDTH-1:0] i_ld_addr,
    input  logic [DWIDTH-1:0] i_ld_wdata,
    input  logic              i_ld_last,
    output logic              o_ld_gnt,
    output logic              o_mem_rq,
    output logic              o_mem_rnw,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_busy_load
);

    localparam int              CW       = $clog2(LOAD_BURST_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(LOAD_BURST_MAX);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            fe_rvalid_r;
    logic            fe_gnt_s;
    logic            ld_gnt_s;
    logic            yield_s;

    // Grant arbitration; nothing is granted while reset is held so the port
    // is quiet the moment reset asserts.
    always_comb begin
        fe_gnt_s = 1'b0;
        ld_gnt_s = 1'b0;
        yield_s  = 1'b0;
        if (!i_reset) begin
            fe_gnt_s = 1'b0;
            ld_gnt_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // Loader has priority over fetch when idle.
                    ld_gnt_s = i_ld_req;
                    fe_gnt_s = i_fe_req & ~i_ld_req;
                end
                S_LOAD: begin
                    // Fairness yield beats a pending loader beat, even a last one.
                    if ((cnt_r == CNT_MAX) && i_fe_req) begin
                        yield_s  = 1'b1;
                        fe_gnt_s = 1'b1;
                    end else begin
                        ld_gnt_s = i_ld_req;
                    end
                end
                default: begin
                    fe_gnt_s = 1'b0;
                    ld_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Burst state, saturating beat counter and read-valid pipeline register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            fe_rvalid_r <= 1'b0;
        end else begin
            fe_rvalid_r <= fe_gnt_s;
            case (state_r)
                S_IDLE: begin
                    if (ld_gnt_s && !i_ld_last) begin
                        state_r <= S_LOAD;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= S_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                S_LOAD: begin
                    if (yield_s) begin
                        cnt_r <= CNT_ZERO;
                    end else if (ld_gnt_s) begin
                        if (i_ld_last) begin
                            state_r <= S_IDLE;
                            cnt_r   <= CNT_ZERO;
                        end else if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        // Loader idle mid-burst: port stays locked, count holds.
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign o_fe_gnt    = fe_gnt_s;
    assign o_ld_gnt    = ld_gnt_s;
    assign o_fe_stall  = i_fe_req & ~fe_gnt_s;
    assign o_fe_rvalid = fe_rvalid_r;
    assign o_fe_rdata  = fe_rvalid_r ? i_mem_rdata : {DWIDTH{1'b0}};
    assign o_mem_rq    = fe_gnt_s | ld_gnt_s;
    assign o_mem_rnw   = ~ld_gnt_s;
    assign o_mem_addr  = ld_gnt_s ? i_ld_addr : (fe_gnt_s ? i_fe_addr : {AWIDTH{1'b0}});
    assign o_mem_wdata = ld_gnt_s ? i_ld_wdata : {DWIDTH{1'b0}};
    assign o_busy_load = (state_r == S_LOAD);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
// Directed scenarios with hand-computed expectations plus a randomized phase.
// A behavioural model (burst flag + beats-since-yield count) predicts every
// output on every cycle; a negedge process compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int MAXB = 8;

    logic        i_clk;
    logic        i_reset;
    logic        i_fe_req;
    logic [31:0] i_fe_addr;
    logic        o_fe_gnt;
    logic        o_fe_stall;
    logic        o_fe_rvalid;
    logic [31:0] o_fe_rdata;
    logic        i_ld_req;
    logic [31:0] i_ld_addr;
    logic [31:0] i_ld_wdata;
    logic        i_ld_last;
    logic        o_ld_gnt;
    logic        o_mem_rq;
    logic        o_mem_rnw;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_busy_load;

    int tests = 0;
    int fails = 0;

    imem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .LOAD_BURST_MAX(MAXB)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_fe_req(i_fe_req), .i_fe_addr(i_fe_addr),
        .o_fe_gnt(o_fe_gnt), .o_fe_stall(o_fe_stall),
        .o_fe_rvalid(o_fe_rvalid), .o_fe_rdata(o_fe_rdata),
        .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata),
        .i_ld_last(i_ld_last), .o_ld_gnt(o_ld_gnt),
        .o_mem_rq(o_mem_rq), .o_mem_rnw(o_mem_rnw), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_busy_load(o_busy_load)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_burst;     // a multi-beat burst holds the port
    int          m_run;       // loader beats since burst start / last yield
    bit          m_prev_fe;   // fetch was granted last cycle
    logic [31:0] m_prev_addr; // address of that fetch

    function automatic bit exp_yield();
        return m_burst && (m_run == MAXB) && (i_fe_req === 1'b1);
    endfunction
    function automatic bit exp_ld();
        if (!m_burst) return i_ld_req === 1'b1;
        return !exp_yield() && (i_ld_req === 1'b1);
    endfunction
    function automatic bit exp_fe();
        if (!m_burst) return (i_fe_req === 1'b1) && (i_ld_req !== 1'b1);
        return exp_yield();
    endfunction

    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            m_burst     <= 1'b0;
            m_run       <= 0;
            m_prev_fe   <= 1'b0;
            m_prev_addr <= 32'h0;
        end else begin
            if (exp_yield()) begin
                m_run <= 0;
            end else if (exp_ld()) begin
                if (i_ld_last) begin
                    m_burst <= 1'b0;
                    m_run   <= 0;
                end else if (!m_burst) begin
                    m_burst <= 1'b1;
                    m_run   <= 1;
                end else begin
                    m_run <= (m_run < MAXB) ? m_run + 1 : MAXB;
                end
            end
            m_prev_fe   <= exp_fe();
            m_prev_addr <= i_fe_addr;
        end
    end

    // Memory: read data for address A is A+0xA0, garbage when no read issued.
    logic        rd_q = 1'b0;
    logic [31:0] rd_addr_q = 32'h0;
    always @(negedge i_clk) begin
        rd_q      <= o_mem_rq & o_mem_rnw;
        rd_addr_q <= o_mem_addr;
    end
    always @(posedge i_clk) begin
        i_mem_rdata <= rd_q ? rd_addr_q + 32'hA0 : $urandom;
    end

    // Per-cycle compare against the model.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            check("rst_busy",   32'(o_busy_load), 32'h0);
            check("rst_rvalid", 32'(o_fe_rvalid), 32'h0);
            check("rst_rdata",  o_fe_rdata, 32'h0);
        end else begin
            check("fe_gnt",  32'(o_fe_gnt), 32'(exp_fe()));
            check("ld_gnt",  32'(o_ld_gnt), 32'(exp_ld()));
            check("stall",   32'(o_fe_stall), 32'(i_fe_req && !exp_fe()));
            check("rvalid",  32'(o_fe_rvalid), 32'(m_prev_fe));
            check("rdata",   o_fe_rdata, m_prev_fe ? m_prev_addr + 32'hA0 : 32'h0);
            check("mem_rq",  32'(o_mem_rq), 32'(exp_fe() || exp_ld()));
            check("mem_rnw", 32'(o_mem_rnw), 32'(!exp_ld()));
            check("mem_addr", o_mem_addr,
                  exp_ld() ? i_ld_addr : (exp_fe() ? i_fe_addr : 32'h0));
            check("mem_wdata", o_mem_wdata, exp_ld() ? i_ld_wdata : 32'h0);
            check("busy",    32'(o_busy_load), 32'(m_burst));
        end
    end

    // ---------------- directed burst driver ----------------
    int b_cycles, b_stall, b_busy, b_writes, b_order_bad;
    int yield_at[$];

    task automatic do_burst(input logic [31:0] base, input int n, input bit fe);
        int beat = 0;
        int cyc  = 0;
        b_stall = 0; b_busy = 0; b_order_bad = 0;
        yield_at.delete();
        i_fe_req = fe;
        while (beat < n && cyc < 200) begin
            i_ld_req   = 1'b1;
            i_ld_addr  = base + 32'(4 * beat);
            i_ld_wdata = 32'hC000_0000 + 32'(beat);
            i_ld_last  = (beat == n - 1);
            i_fe_addr  = 32'h2000 + 32'(4 * cyc);
            @(negedge i_clk);
            b_stall += int'(o_fe_stall);
            b_busy  += int'(o_busy_load);
            if (o_fe_gnt) yield_at.push_back(cyc);
            if (o_ld_gnt) begin
                if (o_mem_addr !== base + 32'(4 * beat)) b_order_bad++;
                beat++;
            end
            cyc++;
            @(posedge i_clk); #1;
        end
        i_ld_req  = 1'b0;
        i_ld_last = 1'b0;
        b_cycles  = cyc;
        b_writes  = beat;
        check("burst_complete", 32'(beat), 32'(n));
    endtask

    initial begin
        int y0, y1;
        i_reset = 1'b0; i_fe_req = 1'b0; i_fe_addr = 32'h0;
        i_ld_req = 1'b0; i_ld_addr = 32'h0; i_ld_wdata = 32'h0; i_ld_last = 1'b0;
        i_mem_rdata = 32'h0;

        // Reset with inputs toggling, then release with requests low.
        repeat (5) begin
            @(posedge i_clk); #1;
            i_fe_req = 1'($urandom); i_ld_req = 1'($urandom); i_ld_last = 1'($urandom);
            i_fe_addr = $urandom; i_ld_addr = $urandom; i_ld_wdata = $urandom;
        end
        @(posedge i_clk); #1;
        i_fe_req = 1'b0; i_ld_req = 1'b0; i_ld_last = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rel_fe_gnt", 32'(o_fe_gnt), 32'h0);
        check("rel_ld_gnt", 32'(o_ld_gnt), 32'h0);
        check("rel_mem_rq", 32'(o_mem_rq), 32'h0);
        check("rel_mem_rnw", 32'(o_mem_rnw), 32'h1);
        check("rel_mem_addr", o_mem_addr, 32'h0);
        check("rel_busy", 32'(o_busy_load), 32'h0);
        check("rel_rvalid", 32'(o_fe_rvalid), 32'h0);

        // Fetch streaming 0x0, 0x4, 0x8.
        @(posedge i_clk); #1;
        i_fe_req = 1'b1; i_fe_addr = 32'h0;
        @(negedge i_clk);
        check("stream_gnt0", 32'(o_fe_gnt), 32'h1);
        check("stream_stall0", 32'(o_fe_stall), 32'h0);
        @(posedge i_clk); #1; i_fe_addr = 32'h4;
        @(negedge i_clk);
        check("stream_rv0", 32'(o_fe_rvalid), 32'h1);
        check("stream_rd0", o_fe_rdata, 32'hA0);
        @(posedge i_clk); #1; i_fe_addr = 32'h8;
        @(negedge i_clk);
        check("stream_rd1", o_fe_rdata, 32'hA4);
        @(posedge i_clk); #1; i_fe_req = 1'b0;
        @(negedge i_clk);
        check("stream_rd2", o_fe_rdata, 32'hA8);
        @(posedge i_clk); #1;

        // Contended 3-beat burst.
        do_burst(32'h100, 3, 1'b1);
        check("c3_stall", 32'(b_stall), 32'd3);
        check("c3_busy", 32'(b_busy), 32'd2);
        check("c3_cycles", 32'(b_cycles), 32'd3);
        check("c3_order", 32'(b_order_bad), 32'd0);
        @(negedge i_clk);
        check("c3_fe_after", 32'(o_fe_gnt), 32'h1);
        @(posedge i_clk); #1;

        // Fairness yield over a 20-beat burst.
        do_burst(32'h400, 20, 1'b1);
        y0 = (yield_at.size() > 0) ? yield_at[0] : -1;
        y1 = (yield_at.size() > 1) ? yield_at[1] : -1;
        check("y_count", 32'(yield_at.size()), 32'd2);
        check("y_first", 32'(y0), 32'd8);
        check("y_second", 32'(y1), 32'd17);
        check("y_writes", 32'(b_writes), 32'd20);
        check("y_cycles", 32'(b_cycles), 32'd22);
        check("y_order", 32'(b_order_bad), 32'd0);
        @(negedge i_clk);
        check("y_fe_after", 32'(o_fe_gnt), 32'h1);
        @(posedge i_clk); #1;

        // Single-beat burst.
        do_burst(32'h800, 1, 1'b1);
        check("s1_writes", 32'(b_writes), 32'd1);
        check("s1_busy", 32'(b_busy), 32'd0);
        @(negedge i_clk);
        check("s1_fe_after", 32'(o_fe_gnt), 32'h1);
        check("s1_busy_after", 32'(o_busy_load), 32'h0);
        @(posedge i_clk); #1;
        i_fe_req = 1'b0;

        // Reset mid-cycle during beat 4 of a burst.
        for (int b = 0; b < 3; b++) begin
            i_ld_req = 1'b1; i_ld_last = 1'b0;
            i_ld_addr = 32'hA00 + 32'(4 * b); i_ld_wdata = 32'(b);
            @(posedge i_clk); #1;
        end
        i_ld_addr = 32'hA0C;
        #2;
        check("mid_busy_pre", 32'(o_busy_load), 32'h1);
        i_reset = 1'b0;
        #1;
        check("mid_busy", 32'(o_busy_load), 32'h0);
        check("mid_ld_gnt", 32'(o_ld_gnt), 32'h0);
        check("mid_mem_rq", 32'(o_mem_rq), 32'h0);
        check("mid_rvalid", 32'(o_fe_rvalid), 32'h0);
        i_ld_req = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end
        i_reset = 1'b1; i_fe_req = 1'b1; i_fe_addr = 32'h40;
        @(negedge i_clk);
        check("mid_fe_gnt", 32'(o_fe_gnt), 32'h1);
        check("mid_busy_post", 32'(o_busy_load), 32'h0);
        @(posedge i_clk); #1;
        i_fe_req = 1'b0;
        @(negedge i_clk);
        check("mid_rdata", o_fe_rdata, 32'hE0);

        // Randomized phase with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge i_clk); #1;
            i_reset    = ($urandom_range(0, 99) != 0);
            i_fe_req   = ($urandom_range(0, 1) == 0);
            i_ld_req   = ($urandom_range(0, 2) != 0);
            i_ld_last  = ($urandom_range(0, 5) == 0);
            i_fe_addr  = $urandom & 32'hFFFF_FFFC;
            i_ld_addr  = $urandom & 32'hFFFF_FFFC;
            i_ld_wdata = $urandom;
        end
        @(posedge i_clk); #1;
        i_reset = 1'b1; i_fe_req = 1'b0; i_ld_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single instruction-memory port (icache `rq`/`rnw`/addr/data) between the frontend fetch path (read) and the boot/program loader (write). It sequences loader write bursts atomically, with a bounded fairness yield to fetch. It returns fetch read data with fixed one-cycle latency and raises a stall to the frontend whenever fetch is not granted. It sits between `frontend` PC/fetch logic and `icache`.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, `AWIDTH`, data/instruction width
- `LOAD_BURST_MAX`, 8, consecutive loader beats allowed while fetch waits; must be ≥1
- `i_clk`  in  1  clock; all state changes on its rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_fe_req`  in  1  fetch read request
- `i_fe_addr`  in  AWIDTH  fetch PC
- `o_fe_gnt`  out  1  fetch owns the port this cycle
- `o_fe_stall`  out  1  `i_fe_req & ~o_fe_gnt`
- `o_fe_rvalid`  out  1  read data valid; one cycle after `o_fe_gnt`
- `o_fe_rdata`  out  DWIDTH  `i_mem_rdata` when `o_fe_rvalid`, else 0
- `i_ld_req`  in  1  loader write beat request
- `i_ld_addr`  in  AWIDTH  loader write address
- `i_ld_wdata`  in  DWIDTH  loader write data
- `i_ld_last`  in  1  the current beat is the final beat of the burst
- `o_ld_gnt`  out  1  the loader beat is accepted this cycle
- `o_mem_rq`  out  1  memory request
- `o_mem_rnw`  out  1  1 = read (fetch), 0 = write (loader)
- `o_mem_addr`  out  AWIDTH  muxed address
- `o_mem_wdata`  out  DWIDTH  `i_ld_wdata` when `o_ld_gnt`, else 0
- `i_mem_rdata`  in  DWIDTH  read data, valid the cycle after a read request
- `o_busy_load`  out  1  a loader burst is in progress (state S_LOAD)

## Operation
- **State machine.** Two states, S_IDLE and S_LOAD. Beat counter `cnt` is `$clog2(LOAD_BURST_MAX+1)` bits wide and saturates.
- **S_IDLE arbitration.**
  - The loader has priority: if `i_ld_req`, `o_ld_gnt=1` and `o_fe_gnt=0`.
  - Otherwise `o_fe_gnt=i_fe_req`.
  - A granted loader beat with `i_ld_last=0` moves to S_LOAD with `cnt<=1`.
  - A granted loader beat with `i_ld_last=1` is a single-beat burst; the block stays in S_IDLE.
- **S_LOAD (port locked to the loader).**
  - Fetch is never granted in S_LOAD, except on a yield cycle.
  - **Yield.** When `cnt==LOAD_BURST_MAX` and `i_fe_req`: `o_fe_gnt=1`, `o_ld_gnt=0`, `cnt<=0`, state stays S_LOAD.
  - **Normal beat.** Otherwise `o_ld_gnt=i_ld_req`. On a granted beat, `cnt<=cnt+1`, saturating at `LOAD_BURST_MAX`.
  - **End of burst.** A granted beat with `i_ld_last` returns to S_IDLE with `cnt<=0`.
  - If the loader idles in S_LOAD, the port stays idle and locked. `cnt` holds, so fetch waits until the next yield condition is reached.
- **Memory mux.**
  - `o_mem_rq = o_fe_gnt | o_ld_gnt`
  - `o_mem_rnw = ~o_ld_gnt`
  - `o_mem_addr = o_ld_gnt ? i_ld_addr : o_fe_gnt ? i_fe_addr : 0`
- **Exclusivity.** `o_fe_gnt` and `o_ld_gnt` are never both 1.

## Timing
- Grants and memory outputs are combinational from the current state and requests, so a grant is issued in the same cycle as the request.
- State and `cnt` update on the rising clock edge.
- `o_fe_rvalid` is a register holding the previous cycle's `o_fe_gnt`. Read latency is exactly 1 cycle, and back-to-back fetch grants give `o_fe_rvalid` on consecutive cycles.
- `o_fe_rdata` is combinational: `i_mem_rdata` gated by `o_fe_rvalid`.
- A loader beat completes in its grant cycle; there is no write response.
- **Reset** (asynchronous on the falling edge of `i_reset`; release synchronous to `i_clk`):
  - state is S_IDLE, `cnt=0`, `o_fe_rvalid=0`.
  - With all requests low, every output is 0 (`o_mem_rnw` is 1).
  - Reset in mid-burst abandons the burst; the loader must restart it.
  - Reset on the cycle after a fetch grant drops that `o_fe_rvalid`.
- **Simultaneous events.**
  - `i_ld_req & i_fe_req` in S_IDLE: the loader wins and the fetch stalls.
  - A yield cycle coinciding with `i_ld_req & i_ld_last`: the yield wins. The last beat is granted on the next cycle and then ends the burst.

## Test plan
- **Reset values.** Assert `i_reset=0` with random inputs toggling; release with all requests low -> every output 0 except `o_mem_rnw=1`, state S_IDLE.
- **Fetch streaming.** Hold `i_fe_req=1`, addr 0x0, 0x4, 0x8, and the memory model returns 0xA0, 0xA4, 0xA8 -> grant every cycle, `o_fe_stall=0`, `o_fe_rvalid` one cycle later carrying the matching data.
- **Contended 3-beat burst.** 3-beat loader burst (0x100, 0x104, 0x108, last on the third) with `i_fe_req` held -> `o_ld_gnt` on 3 consecutive cycles, `o_mem_rnw=0`, `o_fe_stall=1` for exactly 3 cycles, `o_busy_load=1` for 2 cycles, then fetch granted.
- **Fairness yield.** `LOAD_BURST_MAX=8`, 20-beat burst, fetch requesting throughout -> fetch granted on the cycles after loader beats 8 and 16, and the burst still completes all 20 writes in order.
- **Single-beat burst.** `i_ld_req & i_ld_last` from S_IDLE while `i_fe_req=1` -> 1 write, `o_busy_load` stays 0, fetch granted the next cycle.
- **Reset mid-burst.** Pull `i_reset` low mid-cycle during beat 4 of a burst -> outputs clear immediately without waiting for a clock edge; after release a new fetch is granted from S_IDLE.
